xilinx_dram_wport_arbiter: RTL

//  Shares the single synchronous write port of one LUTRAM instance (64/128/256 x W) among NREQ requesters.

---
 rtl/xilinx_dram_pkg.sv | 22 ++
 rtl/xilinx_dram_rr_pick.sv | 45 ++++
 rtl/xilinx_dram_wport_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/xilinx_dram_pkg.sv
// ---------------------------------------------------------------------------
// xilinx_dram_pkg
//   Shared types and helpers for the LUTRAM write-port arbiter.
//   - state_e     : arbiter FSM states (CLEAR sweep, RUN arbitration)
//   - ABITS_MIN/MAX : legal LUTRAM address widths (64..256 deep)
//   - dram_depth  : number of words for a given address width
// ---------------------------------------------------------------------------
package xilinx_dram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int ABITS_MIN = 6;
    localparam int ABITS_MAX = 8;

    function automatic int dram_depth(input int abits);
        return 1 << abits;
    endfunction

endpackage

// File: rtl/xilinx_dram_rr_pick.sv
// ---------------------------------------------------------------------------
// xilinx_dram_rr_pick
//   Combinational round-robin picker. Selects the first asserted request
//   starting at index ptr and wrapping modulo NREQ.
//   Ports:
//     req   in  NREQ            request vector
//     ptr   in  clog2(NREQ)     highest-priority index this cycle (< NREQ)
//     grant out NREQ            one-hot selected request (zero if none)
//     idx   out clog2(NREQ)     index of the selected request
//     any   out 1               at least one request asserted
// ---------------------------------------------------------------------------
module xilinx_dram_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);

    localparam int IW = $clog2(NREQ);

    always_comb begin
        int c;
        // NOTE: every output gets a default before the loop so no path
        // leaves a signal unassigned, which would infer a latch.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr is always < NREQ, so one subtraction is enough to wrap.
            c = int'(ptr) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            if (!any && req[c]) begin
                any      = 1'b1;
                idx      = IW'(c);
                grant[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xilinx_dram_wport_arbiter.sv
// ---------------------------------------------------------------------------
// xilinx_dram_wport_arbiter
//   Shares the single synchronous write port of one LUTRAM bank among NREQ
//   requesters with round-robin arbitration, one write per cycle. All RAM_*
//   outputs are registered, so an accept in cycle N appears at the RAM in N+1.
//
//   Optional feature: define XILINX_DRAM_ARB_CLEAR_EN to add a post-reset
//   sweep that writes zero to every address (2**ABITS cycles) before
//   arbitration starts. Without it the arbiter runs from the first cycle
//   after SRST and BUSY is tied low.
//
//   Ports:
//     CLK1      in  1            write clock
//     SRST      in  1            synchronous active-high reset
//     REQ_VALID in  NREQ         per-requester write request
//     REQ_ADDR  in  NREQ*ABITS   packed addresses, requester i at [i*ABITS +: ABITS]
//     REQ_DATA  in  NREQ*W       packed data, requester i at [i*W +: W]
//     REQ_READY out NREQ         one-hot grant; transfer on VALID & READY
//     FREEZE    in  1            suppress all grants
//     RAM_WADDR out ABITS        registered write address
//     RAM_WDATA out W            registered write data
//     RAM_WE    out 1            registered write enable
//     GRANT_ID  out clog2(NREQ)  index of the last accepted requester
//     BUSY      out 1            clear sweep in progress
// ---------------------------------------------------------------------------
module xilinx_dram_wport_arbiter
    import xilinx_dram_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int ABITS = 7,
    parameter int W     = 1
) (
    input  logic                    CLK1,
    input  logic                    SRST,
    input  logic [NREQ-1:0]         REQ_VALID,
    input  logic [NREQ*ABITS-1:0]   REQ_ADDR,
    input  logic [NREQ*W-1:0]       REQ_DATA,
    output logic [NREQ-1:0]         REQ_READY,
    input  logic                    FREEZE,
    output logic [ABITS-1:0]        RAM_WADDR,
    output logic [W-1:0]            RAM_WDATA,
    output logic                    RAM_WE,
    output logic [$clog2(NREQ)-1:0] GRANT_ID,
    output logic                    BUSY
);

    localparam int IW = $clog2(NREQ);

`ifdef XILINX_DRAM_ARB_CLEAR_EN
    localparam state_e ST_RESET = ST_CLEAR;
    localparam logic [ABITS-1:0] CLR_LAST = ABITS'(dram_depth(ABITS) - 1);
`else
    localparam state_e ST_RESET = ST_RUN;
`endif

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              ram_we_q, ram_we_d;
    logic [ABITS-1:0]  ram_waddr_q, ram_waddr_d;
    logic [W-1:0]      ram_wdata_q, ram_wdata_d;
    logic [IW-1:0]     grant_id_q, grant_id_d;
`ifdef XILINX_DRAM_ARB_CLEAR_EN
    logic [ABITS-1:0]  clr_cnt_q, clr_cnt_d;
`endif

    logic [NREQ-1:0]   pick_grant;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              ready_en;
    logic              accept;

    xilinx_dram_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (REQ_VALID),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Grants are withheld during reset so nothing transfers into a write
    // that the reset is about to drop.
    assign ready_en  = (state_q == ST_RUN) && !FREEZE && !SRST;
    assign accept    = ready_en && pick_any;
    assign REQ_READY = ready_en ? pick_grant : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ram_we_d    = 1'b0;
        ram_waddr_d = ram_waddr_q;
        ram_wdata_d = ram_wdata_q;
        grant_id_d  = grant_id_q;
`ifdef XILINX_DRAM_ARB_CLEAR_EN
        clr_cnt_d   = clr_cnt_q;
`endif
        case (state_q)
            ST_CLEAR: begin
`ifdef XILINX_DRAM_ARB_CLEAR_EN
                ram_we_d    = 1'b1;
                ram_waddr_d = clr_cnt_q;
                ram_wdata_d = '0;
                clr_cnt_d   = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = ST_RUN;
                end
`else
                state_d = ST_RUN;
`endif
            end
            ST_RUN: begin
                if (accept) begin
                    ram_we_d    = 1'b1;
                    ram_waddr_d = REQ_ADDR[int'(pick_idx)*ABITS +: ABITS];
                    ram_wdata_d = REQ_DATA[int'(pick_idx)*W +: W];
                    grant_id_d  = pick_idx;
                    ptr_d       = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge CLK1) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (SRST) begin
            state_q     <= ST_RESET;
            ptr_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
            grant_id_q  <= '0;
`ifdef XILINX_DRAM_ARB_CLEAR_EN
            clr_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ram_we_q    <= ram_we_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
            grant_id_q  <= grant_id_d;
`ifdef XILINX_DRAM_ARB_CLEAR_EN
            clr_cnt_q   <= clr_cnt_d;
`endif
        end
    end

    assign RAM_WE    = ram_we_q;
    assign RAM_WADDR = ram_waddr_q;
    assign RAM_WDATA = ram_wdata_q;
    assign GRANT_ID  = grant_id_q;

`ifdef XILINX_DRAM_ARB_CLEAR_EN
    assign BUSY = (state_q == ST_CLEAR);
`else
    assign BUSY = 1'b0;
`endif

endmodule
